// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Purpose  : Raster timing generator (hcount/vcount, active-low syncs,
//            visible flag, frame strobe). Optional macro VGA_CLKDIV2_EN
//            derives the pixel enable by dividing clk by two.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick,
    output logic       pix_en
);

    localparam int c_H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS      = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS      = 10'(V_VIS);
    localparam logic [9:0] c_HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_frame_tick;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_h_wrap;
    logic       w_v_wrap;

`ifdef VGA_CLKDIV2_EN
    logic r_pix_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end

    assign pix_en = r_pix_en;
`else
    assign pix_en = 1'b1;
`endif

    assign w_h_wrap = (r_hcount == c_H_LAST);
    assign w_v_wrap = (r_vcount == c_V_LAST);
    assign w_h_next = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
    assign w_v_next = w_h_wrap ? (w_v_wrap ? 10'd0 : r_vcount + 10'd1) : r_vcount;

    // Syncs and visible flag decode the next position so they land in the
    // same cycle as the counters they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount     <= c_H_LAST;
            r_vcount     <= c_V_LAST;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_video_on   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (pix_en) begin
                r_hcount     <= w_h_next;
                r_vcount     <= w_v_next;
                r_hsync      <= !((w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST));
                r_vsync      <= !((w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST));
                r_video_on   <= (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
                r_frame_tick <= (w_h_next == 10'd0) && (w_v_next == c_V_VIS);
            end
        end
    end

    assign hcount     = r_hcount;
    assign vcount     = r_vcount;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Purpose  : Self-checking bench for vga_timing: default-size instance plus a
//            reduced-size instance so whole frames fit a short run.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing;

`ifdef VGA_CLKDIV2_EN
    localparam int c_F = 2;
`else
    localparam int c_F = 1;
`endif

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       ft;
        logic       pe;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] d_h, d_v, s_h, s_v;
    logic d_hs, d_vs, d_vo, d_ft, d_pe;
    logic s_hs, s_vs, s_vo, s_ft, s_pe;

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit started = 1'b0;
    int tick_n[$];

    vga_timing u_dut (
        .clk(clk), .reset(reset), .hcount(d_h), .vcount(d_v), .hsync(d_hs),
        .vsync(d_vs), .video_on(d_vo), .frame_tick(d_ft), .pix_en(d_pe)
    );

    // 80 x 55 raster: 4400 positions per frame
    vga_timing #(
        .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk(clk), .reset(reset), .hcount(s_h), .vcount(s_v), .hsync(s_hs),
        .vsync(s_vs), .video_on(s_vo), .frame_tick(s_ft), .pix_en(s_pe)
    );

    // n = clk edges since the last reset edge; outputs follow from the
    // number of pixel advances modulo the frame size.
    function automatic obs_t model(int cyc, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        obs_t o;
        int ht, vt, adv, idx, h, v;
        bit adv_last;
        ht  = hv + hf + hsw + hb;
        vt  = vv + vf + vsw + vb;
        adv = (c_F == 2) ? cyc / 2 : cyc;
        idx = (adv + ht * vt - 1) % (ht * vt);
        h   = idx % ht;
        v   = idx / ht;
        adv_last = (cyc > 0) && ((c_F == 1) || (cyc % 2 == 0));
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
        o.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
        o.vo = (h < hv) && (v < vv);
        o.ft = adv_last && (h == 0) && (v == vv);
        o.pe = (c_F == 2) ? 1'(cyc % 2) : 1'b1;
        return o;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d: got h=%0d v=%0d hs=%b vs=%b vo=%b ft=%b pe=%b, expected h=%0d v=%0d hs=%b vs=%b vo=%b ft=%b pe=%b",
                     name, n, act.h, act.v, act.hs, act.vs, act.vo, act.ft, act.pe,
                     exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.ft, exp.pe);
        end
    endtask

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            n       <= 0;
            started <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            compare("dflt", {d_h, d_v, d_hs, d_vs, d_vo, d_ft, d_pe},
                    model(n, 640, 16, 96, 48, 480, 10, 2, 33));
            compare("small", {s_h, s_v, s_hs, s_vs, s_vo, s_ft, s_pe},
                    model(n, 64, 4, 8, 4, 48, 2, 2, 3));
            if (s_ft) tick_n.push_back(n);
        end
    end

    initial begin
        int hs_low, vo_hi;
        bit found;

        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_lit("reset_hcount", int'(d_h), 799);
            check_lit("reset_vcount", int'(d_v), 524);
            check_lit("reset_tick", int'(d_ft), 0);
        end
        reset = 1'b0;

        hs_low = 0;
        vo_hi  = 0;
        for (int i = 1; i <= 1600 * c_F; i++) begin
            @(negedge clk);
            if (!d_hs) hs_low++;
            if (d_vo) vo_hi++;
            if (i == c_F) begin
                check_lit("first_hcount", int'(d_h), 0);
                check_lit("first_vcount", int'(d_v), 0);
                check_lit("first_video_on", int'(d_vo), 1);
            end
        end
        check_lit("hsync_low_2lines", hs_low, 192 * c_F);
        check_lit("video_on_2lines", vo_hi, 1280 * c_F);

        while (n < c_F * (3841 + 4400) + 5) @(negedge clk);
        check_lit("tick_count", tick_n.size(), 2);
        if (tick_n.size() >= 2) begin
            check_lit("first_tick_n", tick_n[0], 3841 * c_F);
            check_lit("tick_period", tick_n[1] - tick_n[0], 4400 * c_F);
        end

        found = 1'b0;
        for (int i = 0; i < 10000 * c_F && !found; i++) begin
            @(negedge clk);
            if (s_h == 10'd30 && s_v == 10'd20) found = 1'b1;
        end
        check_lit("found_30_20", int'(found), 1);
        reset = 1'b1;
        tick_n.delete();
        @(negedge clk);
        check_lit("midreset_small_h", int'(s_h), 79);
        check_lit("midreset_small_v", int'(s_v), 54);
        check_lit("midreset_dflt_h", int'(d_h), 799);
        check_lit("midreset_dflt_v", int'(d_v), 524);
        reset = 1'b0;

        while (n < c_F * 3841 + 5) @(negedge clk);
        check_lit("tick_after_reset_count", tick_n.size(), 1);
        if (tick_n.size() >= 1)
            check_lit("tick_after_reset_n", tick_n[0], 3841 * c_F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator for the Pong display path, directly upstream of the ball, paddle and score renderers.
- Produces the pixel coordinates (hcount, vcount), active-low sync pulses, a visible-area flag and a one-cycle frame strobe.
- Game objects use the frame strobe to update their positions during vertical blanking, without sampling vsync edges.
- Default timing is 640x480 @ 60 Hz, 800x525 total.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high when hcount<H_VIS and vcount<V_VIS
- frame_tick  out  1  single-clk pulse at start of vertical blank
- pix_en  out  1  pixel advance enable; downstream stages register on clk qualified by pix_en

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Derived totals: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
- Reset values (held every cycle reset=1):
  - hcount=H_TOTAL-1 (799), vcount=V_TOTAL-1 (524)
  - hsync=1, vsync=1, video_on=0, frame_tick=0
  - pix_en: see Optional Feature.
- Advance: on a clk edge with reset=0 and pix_en=1:
  - hcount increments.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
  - The first advance after reset therefore yields (0,0).
- Hold: when pix_en=0, the counters and hsync/vsync/video_on hold.
- Output alignment: hsync, vsync and video_on are registered, decoded from the next counter values. They are always consistent with the hcount/vcount present in the same cycle (zero skew; no combinational decode on the outputs).
- hsync = 0 iff H_VIS+H_FP <= hcount <= H_VIS+H_FP+H_SYNC-1 (656..751).
- vsync = 0 iff V_VIS+V_FP <= vcount <= V_VIS+V_FP+V_SYNC-1 (490..491), for the whole line including hblank.
- frame_tick:
  - High for exactly one clk cycle: the first cycle in which (hcount,vcount) = (0,V_VIS).
  - Never high during reset.
  - Never high on the reset-release cycle.
- Width rules:
  - Counters are 10-bit unsigned.
  - Parameter sums must be <= 1024. Violating sets is unsupported (no run-time check).
- Reset mid-frame: the next edge forces the reset values regardless of position. There is no partial-line output.

Optional Feature:
- Macro: VGA_CLKDIV2_EN.
- Defined (clk = 50 MHz):
  - An internal toggle flop drives pix_en, reset to 0, high on alternate cycles.
  - Counters advance every second clk.
  - frame_tick remains one clk wide (first of the two cycles at (0,V_VIS)).
- Undefined (clk = 25 MHz pixel clock): pix_en is tied to 1 and counters advance every clk.

Test Plan:
- Reset 5 cycles -> hcount=799, vcount=524, hsync=1, vsync=1, video_on=0, frame_tick=0 throughout.
- Release reset (no divider) -> next cycle (0,0) with video_on=1; video_on falls on the cycle hcount becomes 640 and rises at next line's hcount=0.
- Run 2 lines -> hsync=0 exactly for hcount 656..751, 96 cycles per line, 800-cycle period.
- Run a full frame -> vsync=0 for vcount 490..491 (1600 cycles); (799,524) wraps to (0,0); video_on=0 for all vcount>=480.
- frame_tick -> first pulse when counters reach (0,480); subsequent pulses 420000 clk apart, each 1 clk wide. With VGA_CLKDIV2_EN: 840000 clk apart, still 1 clk wide, pix_en alternating.
- Assert reset for 1 cycle at (300,200) -> next cycle counters (799,524), outputs at reset values; after release, timing resumes from (0,0) with no frame_tick until (0,480).
